// File: rtl/mac_result_buf_if.sv
`default_nettype none
// ============================================================================
// Module  : mac_result_buf_if
// Brief   : Result-stream / drain handshake bundle for mac_result_buf.
// Rev     : 1.0  initial release
// ============================================================================
interface mac_result_buf_if #(
    parameter int W     = 8,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH + 1);

    logic          ena;
    logic          clr_i;
    logic          result_v_i;
    logic [W-1:0]  result_i;
    logic          out_ready_i;
    logic          out_v_o;
    logic [W-1:0]  out_data_o;
    logic          out_last_o;
    logic [LW-1:0] level_o;
    logic          ovf_o;
    logic [7:0]    frame_cnt_o;

    modport master (
        output ena, clr_i, result_v_i, result_i, out_ready_i,
        input  out_v_o, out_data_o, out_last_o, level_o, ovf_o, frame_cnt_o
    );

    modport slave (
        input  ena, clr_i, result_v_i, result_i, out_ready_i,
        output out_v_o, out_data_o, out_last_o, level_o, ovf_o, frame_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/mac_result_buf.sv
`default_nettype none
// ============================================================================
// Module  : mac_result_buf
// Brief   : FIFO buffer for the MAC result stream, tags matrix-last elements.
// Rev     : 1.0  initial release
// ============================================================================
module mac_result_buf #(
    parameter int W     = 8,
    parameter int N     = 2,
    parameter int DEPTH = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    mac_result_buf_if.slave  bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int NN = N * N;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;

    logic [W:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [IW-1:0] idx;
    logic          ovf;
    logic [7:0]    frame_cnt;

    logic          full;
    logic          empty;
    logic          out_v;
    logic          out_last;
    logic          pop;
    logic          push;
    logic          ovf_set;
    logic          last_bit;
    logic [W:0]    head;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign out_v    = bus.ena & ~empty;
    assign pop      = out_v & bus.out_ready_i & ~bus.clr_i;
    assign push     = bus.ena & bus.result_v_i & ~bus.clr_i & (~full | pop);
    assign ovf_set  = bus.ena & bus.result_v_i & full & ~pop & ~bus.clr_i;
    assign last_bit = (idx == IW'(NN - 1));
    assign head     = mem[rd_ptr];
    // RAM is not reset, so gate last with valid to keep it clean after reset
    assign out_last = out_v & head[W];

    assign bus.out_v_o     = out_v;
    assign bus.out_data_o  = head[W-1:0];
    assign bus.out_last_o  = out_last;
    assign bus.level_o     = level;
    assign bus.ovf_o       = ovf;
    assign bus.frame_cnt_o = frame_cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {last_bit, bus.result_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.clr_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            idx       <= '0;
            ovf       <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                idx    <= last_bit ? '0 : idx + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (out_last) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mac_result_buf.sv
`default_nettype none
// ============================================================================
// Module  : tb_mac_result_buf
// Brief   : Queue-model scoreboard bench for mac_result_buf.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mac_result_buf;
    localparam int W     = 8;
    localparam int N     = 2;
    localparam int DEPTH = 8;
    localparam int NN    = N * N;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    mac_result_buf_if #(.W(W), .DEPTH(DEPTH)) bus ();

    mac_result_buf #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: queue of {last, data} plus matrix position and flags
    logic [W:0] mq[$];
    int         m_idx   = 0;
    bit         m_ovf   = 1'b0;
    int         m_frame = 0;
    bit         exp_v;
    bit         m_pop;
    bit         m_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare DUT against model, then advance model to next edge
    always @(negedge clk) begin
        exp_v = bus.ena && (mq.size() > 0);
        chk("level", 32'(bus.level_o), 32'(mq.size()));
        chk("ovf", 32'(bus.ovf_o), 32'(m_ovf));
        chk("frame_cnt", 32'(bus.frame_cnt_o), 32'(m_frame));
        chk("out_v", 32'(bus.out_v_o), 32'(exp_v));
        if (exp_v) begin
            chk("out_data", 32'(bus.out_data_o), 32'(mq[0][W-1:0]));
            chk("out_last", 32'(bus.out_last_o), 32'(mq[0][W]));
        end

        if (!rst_n || bus.clr_i) begin
            mq.delete();
            m_idx   = 0;
            m_ovf   = 1'b0;
            m_frame = 0;
        end else begin
            m_pop = exp_v && bus.out_ready_i;
            m_acc = bus.ena && bus.result_v_i && ((mq.size() < DEPTH) || m_pop);
            if (m_pop) begin
                if (mq[0][W]) m_frame = (m_frame + 1) % 256;
                void'(mq.pop_front());
            end
            if (m_acc) begin
                mq.push_back({(m_idx == NN - 1), bus.result_i});
                m_idx = (m_idx + 1) % NN;
            end else if (bus.ena && bus.result_v_i) begin
                m_ovf = 1'b1;
            end
        end
    end

    task automatic cyc(input bit e, input bit v, input logic [W-1:0] d, input bit r, input bit c);
        bus.ena         = e;
        bus.result_v_i  = v;
        bus.result_i    = d;
        bus.out_ready_i = r;
        bus.clr_i       = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, r, 1'b0);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.ena         = 1'b0;
        bus.clr_i       = 1'b0;
        bus.result_v_i  = 1'b0;
        bus.result_i    = '0;
        bus.out_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming burst with the consumer always ready
        cyc(1, 1, 8'h11, 1, 0);
        cyc(1, 1, 8'h22, 1, 0);
        cyc(1, 1, 8'h33, 1, 0);
        cyc(1, 1, 8'h44, 1, 0);
        idle(3, 1);

        // Fill under stall, overflow on the ninth, then drain
        for (int i = 1; i <= 9; i++) cyc(1, 1, 8'(i), 0, 0);
        idle(10, 1);

        // Full FIFO with simultaneous push and pop
        cyc(1, 0, '0, 0, 1);
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, 8'(8'h60 + i), 0, 0);
        cyc(1, 1, 8'hAA, 1, 0);
        idle(10, 1);

        // Alternating backpressure
        for (int i = 0; i < 8; i++) cyc(1, 1, 8'(8'h10 + i), i[0], 0);
        for (int i = 0; i < 16; i++) cyc(1, 0, '0, i[0], 0);

        // Flush with five entries queued and overflow set
        for (int i = 0; i < 9; i++) cyc(1, 1, 8'(8'h80 + i), 0, 0);
        idle(3, 1);
        cyc(1, 1, 8'hEE, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 1, 8'(8'hC0 + i), 0, 0);
        idle(6, 1);

        // Disabled block ignores results and hides its head
        for (int i = 0; i < 3; i++) cyc(1, 1, 8'(8'hD0 + i), 0, 0);
        cyc(0, 1, 8'hF1, 1, 0);
        cyc(0, 1, 8'hF2, 1, 0);
        cyc(0, 0, '0, 1, 0);
        idle(5, 1);

        // Randomized traffic including flushes and mid-burst resets
        for (int i = 0; i < 800; i++) begin
            bit e;
            e = ($urandom_range(0, 9) != 0);
            rst_n = ($urandom_range(0, 149) != 0);
            cyc(e, ($urandom_range(0, 9) < 6), 8'($urandom),
                ($urandom_range(0, 9) < 5), e && ($urandom_range(0, 79) == 0));
            rst_n = 1'b1;
        end
        idle(12, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mac_result_buf.md
Name: mac_result_buf

Overview:
Downstream stage of the systolic MAC array. It captures the MAC's result stream (result valid + W-bit result, one element per cycle burst) into a small FIFO, tags each entry with its position in the NxN output matrix, and drains it to the chip output through a valid/ready handshake. Result bursts are absorbed even when the consumer stalls, and lost data is flagged by a sticky overflow bit.

Parameters:
W, 8, result element width; equals MAC W
N, 2, matrix dimension; one matrix = N*N results
DEPTH, 8, FIFO entries; power of 2, >= 2
LW, $clog2(DEPTH+1), width of the level output (derived; not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ena  in  1  block enable; gates push and pop
clr_i  in  1  synchronous flush: empties FIFO, clears counters and ovf
result_v_i  in  1  MAC result valid
result_i  in  W  MAC result element
out_ready_i  in  1  consumer ready
out_v_o  out  1  head entry valid
out_data_o  out  W  head entry data
out_last_o  out  1  head entry is element N*N-1 of its matrix
level_o  out  LW  current FIFO occupancy, 0..DEPTH
ovf_o  out  1  sticky overflow; a result was dropped
frame_cnt_o  out  8  matrices fully drained, mod 256

Behaviour:
- Reset (rst_n=0 at posedge clk): wr/rd pointers=0, level=0, element index=0, ovf_o=0, frame_cnt_o=0. Consequently out_v_o=0 and out_last_o=0. out_data_o is don't-care while out_v_o=0. FIFO RAM contents are not reset.
- Storage: DEPTH x (W+1) entries holding {last, data}. The pointer width is log2(DEPTH). Pointers wrap modulo DEPTH. Full/empty are derived from level (level==DEPTH / level==0).
- push = ena & result_v_i & ~clr_i & (level<DEPTH | pop).
- pop = ena & out_v_o & out_ready_i & ~clr_i.
- Element index:
  - Counts 0..N*N-1 on each push, wrapping to 0 after N*N-1.
  - The stored last bit = (index==N*N-1).
  - The index advances only on accepted pushes. Dropped results do not advance it, so a dropped element shifts matrix alignment; this is tolerated and flagged by ovf.
- Simultaneous push+pop:
  - Legal when full (the slot is freed the same cycle): level unchanged.
  - Legal when non-empty: level unchanged.
  - When empty, out_v_o=0 so no pop occurs; only the push happens.
- Overflow: ena & result_v_i & level==DEPTH & ~pop & ~clr_i sets ovf_o=1 next cycle. The element is discarded. ovf_o stays 1 until clr_i or reset.
- Output:
  - Combinational read of the head entry: out_v_o = (level!=0) & ena.
  - out_data_o and out_last_o come from the RAM at rd_ptr.
  - Data and last must stay stable while out_v_o=1 and out_ready_i=0.
- Latency: a push at posedge t into an empty FIFO gives out_v_o=1 after posedge t. Zero-bubble streaming when out_ready_i is held 1: one element out per cycle.
- frame_cnt_o increments by 1 (wrapping at 256) on every pop where out_last_o=1.
- clr_i:
  - Has priority over push and pop.
  - Next cycle: level=0, pointers=0, index=0, ovf_o=0, frame_cnt_o=0.
  - A result_v_i in the same cycle as clr_i is discarded and does not set ovf.
- ena=0: no push, no pop, and out_v_o=0. All state is held and ovf is not set. result_v_i pulses arriving during ena=0 are ignored.
- Reset mid-burst: behaves as reset; partially drained matrices are lost and the index restarts at 0.

Test Plan:
- N=2, DEPTH=8, out_ready_i=1: push 4 results 0x11,0x22,0x33,0x44 on consecutive cycles -> out_data_o emits the same values one per cycle, starting 1 cycle after the first push. out_last_o=1 only on 0x44. frame_cnt_o ends at 1. level_o returns to 0.
- out_ready_i=0, push 8 values 0x01..0x08 -> level_o=8, ovf_o=0. Push a 9th value 0x09 -> ovf_o=1, level_o stays 8. Then drain with ready=1 -> outputs 0x01..0x08; out_last_o=1 on 0x04 and 0x08; frame_cnt_o=2.
- FIFO full and out_ready_i=1 while result_v_i=1 with 0xAA -> the push is accepted with no overflow, level_o stays 8, and 0xAA emerges last.
- Backpressure toggling: out_ready_i alternates 1/0 while pushing 0x10..0x17 -> every element appears exactly once, in order. out_data_o is stable during every ready=0 cycle.
- FIFO holding 5 entries with ovf_o=1: assert clr_i together with result_v_i=1 -> next cycle level_o=0, out_v_o=0, ovf_o=0, frame_cnt_o=0. The next 4 pushes put out_last_o on the 4th.
- ena=0 with 3 entries queued and result_v_i pulsed -> out_v_o=0, level_o stays 3. After ena=1 -> the 3 original entries drain unchanged.
